// File: rtl/klingon_pkg.sv
// klingon_pkg: Klingon glyph segment constants shared by encoder and decoder, plus dwell-length limits
package klingon_pkg;
  localparam logic [6:0] KLG_0     = 7'h3F;
  localparam logic [6:0] KLG_1     = 7'h01;
  localparam logic [6:0] KLG_2     = 7'h41;
  localparam logic [6:0] KLG_3     = 7'h49;
  localparam logic [6:0] KLG_4     = 7'h62;
  localparam logic [6:0] KLG_5     = 7'h5C;
  localparam logic [6:0] KLG_6     = 7'h52;
  localparam logic [6:0] KLG_7     = 7'h64;
  localparam logic [6:0] KLG_8     = 7'h36;
  localparam logic [6:0] KLG_9     = 7'h76;
  localparam logic [6:0] KLG_BLANK = 7'h40;
  localparam int STABLE_MIN = 2;
  localparam int STABLE_MAX = 15;
endpackage

// File: rtl/klingon_glyph_lut.sv
// klingon_glyph_lut: seg[6:0] glyph -> digit[3:0]; illegal patterns give digit F and illegal=1
module klingon_glyph_lut
  import klingon_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       illegal
);
  always_comb begin
    illegal = 1'b0;
    case (seg)
      KLG_0:   digit = 4'd0;
      KLG_1:   digit = 4'd1;
      KLG_2:   digit = 4'd2;
      KLG_3:   digit = 4'd3;
      KLG_4:   digit = 4'd4;
      KLG_5:   digit = 4'd5;
      KLG_6:   digit = 4'd6;
      KLG_7:   digit = 4'd7;
      KLG_8:   digit = 4'd8;
      KLG_9:   digit = 4'd9;
      default: begin
        digit   = 4'hF;
        illegal = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/klingon_seg_decoder.sv
// klingon_seg_decoder: debounces a scanned 4-digit Klingon display (seg_in, digit_sel) into frames out_value/out_err with valid/ready and an overrun pulse on dropped frames
module klingon_seg_decoder
  import klingon_pkg::*;
#(
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  digit_sel,
  output logic [15:0] out_value,
  output logic [3:0]  out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);
  localparam logic [3:0] ST = 4'(STABLE < STABLE_MIN ? STABLE_MIN : STABLE > STABLE_MAX ? STABLE_MAX : STABLE);
  logic [3:0]  digit;
  logic        illegal;
  logic [3:0]  prev_sel, cnt, cnt_n, captured, captured_n, cap_mask, slot_err;
  logic [6:0]  prev_seg;
  logic [15:0] slot_val;
  logic        qual, same, cap, full, load, drop;
  klingon_glyph_lut u_lut (.seg(seg_in), .digit(digit), .illegal(illegal));
  always_comb begin
    qual       = (digit_sel != 4'h0) && ((digit_sel & (digit_sel - 4'd1)) == 4'h0);
    same       = {digit_sel, seg_in} == {prev_sel, prev_seg};
    cnt_n      = !qual ? 4'd0 : !same ? 4'd1 : (cnt == ST) ? ST : cnt + 4'd1;
    // capture only on the transition into saturation, so a long dwell writes once
    cap        = (cnt_n == ST) && (cnt != ST);
    cap_mask   = cap ? digit_sel : 4'h0;
    full       = captured == 4'hF;
    load       = full && (!out_valid || out_ready);
    drop       = full && !load;
    // a capture coinciding with frame hand-off starts the next frame
    captured_n = (full ? 4'h0 : captured) | cap_mask;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sel  <= '0;
      prev_seg  <= '0;
      cnt       <= '0;
      captured  <= '0;
      slot_val  <= '0;
      slot_err  <= '0;
      out_value <= '0;
      out_err   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      prev_sel  <= digit_sel;
      prev_seg  <= seg_in;
      cnt       <= cnt_n;
      captured  <= captured_n;
      overrun   <= drop;
      for (int k = 0; k < 4; k++)
        if (cap_mask[k]) begin
          slot_val[4*k +: 4] <= digit;
          slot_err[k]        <= illegal;
        end
      if (load) begin
        out_value <= slot_val;
        out_err   <= slot_err;
      end
      out_valid <= load | (out_valid & ~out_ready);
    end
  end
endmodule

// File: tb/tb_klingon_seg_decoder.sv
// tb_klingon_seg_decoder: directed self-checking bench for klingon_seg_decoder with STABLE=4
module tb_klingon_seg_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  digit_sel = '0;
  logic        out_ready = 1'b1;
  logic [15:0] out_value;
  logic [3:0]  out_err;
  logic        out_valid, overrun;
  int checks = 0;
  int errors = 0;
  klingon_seg_decoder #(.STABLE(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit_sel(digit_sel),
    .out_value(out_value), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic glyph(input logic [3:0] s, input logic [6:0] g, input int n);
    digit_sel = s;
    seg_in = g;
    repeat (n) @(negedge clk);
  endtask
  task automatic idle(input int n);
    digit_sel = '0;
    seg_in = '0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #1;
    chk("rst_value", out_value, 16'h0);
    chk("rst_err", {12'h0, out_err}, 16'h0);
    chk("rst_valid", {15'h0, out_valid}, 16'h0);
    chk("rst_overrun", {15'h0, overrun}, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    glyph(4'b0001, 7'h49, 4);
    glyph(4'b0010, 7'h76, 4);
    glyph(4'b0100, 7'h3F, 4);
    glyph(4'b1000, 7'h5C, 4);
    chk("a_latency_valid", {15'h0, out_valid}, 16'h0);
    idle(1);
    chk("a_valid", {15'h0, out_valid}, 16'h1);
    chk("a_value", out_value, 16'h5093);
    chk("a_err", {12'h0, out_err}, 16'h0);
    idle(1);
    chk("a_valid_drop", {15'h0, out_valid}, 16'h0);
    chk("a_value_hold", out_value, 16'h5093);
    glyph(4'b0001, 7'h49, 3);
    glyph(4'b0010, 7'h76, 4);
    glyph(4'b0100, 7'h3F, 4);
    glyph(4'b1000, 7'h5C, 4);
    idle(3);
    chk("b_short_dwell_no_frame", {15'h0, out_valid}, 16'h0);
    glyph(4'b0001, 7'h12, 4);
    idle(1);
    chk("b_valid", {15'h0, out_valid}, 16'h1);
    chk("b_value", out_value, 16'h509F);
    chk("b_err", {12'h0, out_err}, 16'h1);
    idle(1);
    glyph(4'b0001, 7'h01, 4);
    glyph(4'b0001, 7'h49, 4);
    glyph(4'b0010, 7'h76, 4);
    glyph(4'b0100, 7'h40, 4);
    glyph(4'b1000, 7'h5C, 4);
    idle(1);
    chk("c_valid", {15'h0, out_valid}, 16'h1);
    chk("c_value", out_value, 16'h5F93);
    chk("c_err", {12'h0, out_err}, 16'h4);
    idle(1);
    out_ready = 1'b0;
    glyph(4'b0001, 7'h01, 4);
    glyph(4'b0010, 7'h41, 4);
    glyph(4'b0100, 7'h49, 4);
    glyph(4'b1000, 7'h62, 4);
    idle(1);
    chk("d_first_valid", {15'h0, out_valid}, 16'h1);
    chk("d_first_value", out_value, 16'h4321);
    glyph(4'b0001, 7'h52, 4);
    glyph(4'b0010, 7'h64, 4);
    glyph(4'b0100, 7'h36, 4);
    glyph(4'b1000, 7'h76, 4);
    chk("d_no_early_overrun", {15'h0, overrun}, 16'h0);
    idle(1);
    chk("d_overrun", {15'h0, overrun}, 16'h1);
    chk("d_held_value", out_value, 16'h4321);
    chk("d_held_valid", {15'h0, out_valid}, 16'h1);
    idle(1);
    chk("d_overrun_pulse_end", {15'h0, overrun}, 16'h0);
    out_ready = 1'b1;
    idle(1);
    chk("d_release_valid", {15'h0, out_valid}, 16'h0);
    chk("d_release_value", out_value, 16'h4321);
    glyph(4'b0011, 7'h3F, 10);
    glyph(4'b0010, 7'h76, 4);
    glyph(4'b0100, 7'h3F, 4);
    glyph(4'b1000, 7'h5C, 4);
    idle(2);
    chk("e_multihot_no_capture", {15'h0, out_valid}, 16'h0);
    rst = 1'b1;
    #1;
    chk("e_async_rst_value", out_value, 16'h0);
    chk("e_async_rst_valid", {15'h0, out_valid}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    glyph(4'b0001, 7'h49, 4);
    idle(2);
    chk("e_partial_discarded", {15'h0, out_valid}, 16'h0);
    glyph(4'b0010, 7'h76, 4);
    glyph(4'b0100, 7'h3F, 4);
    glyph(4'b1000, 7'h5C, 4);
    idle(1);
    chk("e_valid", {15'h0, out_valid}, 16'h1);
    chk("e_value", out_value, 16'h5093);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/klingon_seg_decoder.md
KLINGON_SEG_DECODER -- requirements
Module: klingon_seg_decoder

Interface
REQ-001 Parameter STABLE, default 4 (legal 2..15): consecutive identical samples needed to accept a glyph.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 seg_in  input  7  segment pattern currently driven on the scanned display, bit 0..6 = segment lines out[0]..out[6] of the Klingon glyph encoder.
REQ-005 digit_sel  input  4  one-hot digit strobe of the display scanner; bit k selects digit k.
REQ-006 out_value  output  16  decoded frame; nibble k (bits 4k+3:4k) = digit k.
REQ-007 out_err  output  4  per-digit flag, bit k set = digit k glyph was not a legal Klingon digit.
REQ-008 out_valid  output  1  frame available.
REQ-009 out_ready  input  1  consumer accepts frame.
REQ-010 overrun  output  1  one-cycle pulse, completed frame dropped.

Function
REQ-011 Glyph table (seg_in hex -> digit): 3F->0, 01->1, 41->2, 49->3, 62->4, 5C->5, 52->6, 64->7, 36->8, 76->9; every other pattern is illegal: nibble F, err 1.
REQ-012 Sample qualifies when digit_sel is exactly one-hot; zero or multi-hot sel forces stability counter to 0, no capture.
REQ-013 Counter: qualifying sample equal to previous (sel,seg) pair -> cnt = min(cnt+1, STABLE); qualifying but different -> cnt = 1; previous pair register updated every cycle.
REQ-014 Capture on the edge where cnt transitions to STABLE: decoded nibble and err written to slot k, captured[k] set; exactly one capture per dwell (saturated cnt never recaptures).
REQ-015 Recapture of a slot already captured in the current frame overwrites nibble/err, captured[k] stays 1.
REQ-016 Frame complete when captured == 4'hF; on the following edge, if output register empty or (out_valid && out_ready) that cycle, load out_value/out_err, assert out_valid, clear captured.
REQ-017 Frame complete while out_valid=1 and out_ready=0: frame discarded, captured cleared, overrun pulses 1 cycle; held output unchanged.
REQ-018 out_valid && out_ready with no new frame -> out_valid=0 next cycle; out_value/out_err hold last value.
REQ-019 out_value/out_err stable while out_valid=1 and out_ready=0.
REQ-020 Capture of slot k in the same cycle as frame load: counted toward the new (cleared) frame, i.e. captured = 1<<k after the edge.
REQ-021 Latency: glyph stable from edge n -> slot write at edge n+STABLE-1; fourth slot write at edge m -> out_valid=1 after edge m+1.

Reset
REQ-022 rst=1 asynchronously forces out_value=0, out_err=0, out_valid=0, overrun=0, cnt=0, captured=0, slots=0, prev pair=0.
REQ-023 Reset mid-frame discards partial captures; first accepted glyph after release needs a full STABLE dwell.

Structure
REQ-024 Shared package klingon_pkg holds the ten glyph constants (KLG_0..KLG_9), KLG_BLANK=7'h40, and STABLE range limits; the encoder side uses the same constants.
REQ-025 One combinational sub-module klingon_glyph_lut (seg[6:0] -> digit[3:0], illegal) instantiated once on seg_in; everything else in the top.

Verification
REQ-026 STABLE=4, sel=0001 seg=49 for 4 cycles, then 0010/76, 0100/3F, 1000/5C each 4 cycles, out_ready=1 -> out_value=16'h5093, out_err=0, out_valid one cycle.
REQ-027 sel=0001 seg=49 held only 3 cycles then digit changes -> slot 0 not captured, no frame even after other three digits.
REQ-028 Digit 2 driven seg=40 (blank) -> frame nibble 2 = F, out_err=4'b0100.
REQ-029 out_ready=0, two complete frames -> first held unchanged, overrun pulses once at second completion; out_ready=1 then releases first frame.
REQ-030 sel=0011 for 10 cycles with steady seg -> no capture; rst pulse after 3 slots captured -> outputs 0, next frame requires all 4 digits.
